// File: rtl/mux_13_arbiter.sv
// rtl/mux_13_arbiter.sv - round-robin arbiter owning the select of a shared 13:1 mux
module mux_13_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] req,
    input  logic        done,
    output logic [12:0] gnt,
    output logic [3:0]  sel,
    output logic        valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          ptr;
    logic [3:0]          ptr_nxt;
    logic [3:0]          sel_nxt;
    logic [12:0]         gnt_nxt;
    logic                valid_nxt;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   hold_nxt;

    logic                found;
    logic [3:0]          pick;
    logic [4:0]          sum;
    logic [3:0]          cand;
    logic                hold_hit;
    logic                release_now;

    // Rotating priority search: first set request at or after the pointer, modulo 13
    always_comb begin
        found = 1'b0;
        pick  = 4'd0;
        sum   = 5'd0;
        cand  = 4'd0;
        for (int i = 0; i < 13; i++) begin
            sum  = {1'b0, ptr} + 5'(i);
            cand = (sum > 5'd12) ? 4'(sum - 5'd13) : sum[3:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Release when the owner finishes, withdraws, or exhausts its hold budget
    always_comb begin
        hold_hit    = (MAX_HOLD != 0) && (hold == HOLD_W'(MAX_HOLD));
        release_now = done || !req[sel] || hold_hit;
    end

    // Next-state and registered-output values
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        valid_nxt = valid;
        ptr_nxt   = ptr;
        hold_nxt  = hold;
        case (state)
            IDLE: begin
                gnt_nxt   = 13'd0;
                valid_nxt = 1'b0;
                if (found) begin
                    gnt_nxt   = 13'd1 << pick;
                    sel_nxt   = pick;
                    valid_nxt = 1'b1;
                    hold_nxt  = HOLD_W'(1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_nxt   = 13'd0;
                    valid_nxt = 1'b0;
                    ptr_nxt   = (sel == 4'd12) ? 4'd0 : sel + 4'd1;
                    hold_nxt  = '0;
                    state_nxt = IDLE;
                end else if (hold != {HOLD_W{1'b1}}) begin
                    hold_nxt = hold + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 13'd0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer, hold counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 13'd0;
            sel   <= 4'd0;
            valid <= 1'b0;
            ptr   <= 4'd0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            valid <= valid_nxt;
            ptr   <= ptr_nxt;
            hold  <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_mux_13_arbiter.sv
// tb/tb_mux_13_arbiter.sv - directed self-checking bench for mux_13_arbiter
module tb_mux_13_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] req;
    logic        done;
    logic [12:0] gnt;
    logic [3:0]  sel;
    logic        valid;

    int total = 0;
    int bad   = 0;
    bit inv_on = 1'b0;

    mux_13_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .done  (done),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int k);
        chk({tag, "_valid"}, 16'(valid), 16'd1);
        chk({tag, "_sel"}, 16'(sel), 16'(k));
        chk({tag, "_gnt"}, 16'(gnt), 16'(13'd1 << k));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, 16'(valid), 16'd0);
        chk({tag, "_gnt"}, 16'(gnt), 16'd0);
    endtask

    // Structural invariants sampled away from the active edge
    always @(negedge clk) begin
        if (inv_on) begin
            chk("inv_sel_range", 16'(sel <= 4'd12), 16'd1);
            chk("inv_onehot0", 16'($onehot0(gnt)), 16'd1);
            chk("inv_gnt_sel", 16'(gnt[sel]), 16'(valid));
        end
    end

    initial begin
        rst  = 1'b1;
        req  = 13'h1FFF;
        done = 1'b0;

        // reset held with all requests pending
        tick();
        inv_on = 1'b1;
        chk("rst1_sel", 16'(sel), 16'd0);
        expect_idle("rst1");
        tick();
        chk("rst2_sel", 16'(sel), 16'd0);
        expect_idle("rst2");
        rst = 1'b0;
        tick();
        expect_grant("first", 0);
        req = 13'h0000;
        tick();
        expect_idle("drop_req");

        // single request, done pulse, pointer moves past it
        req = 13'h0020;
        tick();
        expect_grant("single", 5);
        done = 1'b1;
        tick();
        expect_idle("single_done");
        chk("single_sel_kept", 16'(sel), 16'd5);
        done = 1'b0;
        req  = 13'h1FFF;
        tick();
        expect_grant("after5", 6);
        done = 1'b1;
        tick();
        done = 1'b0;

        // full rotation from a fresh pointer
        rst = 1'b1;
        tick();
        expect_idle("rot_rst");
        chk("rot_rst_sel", 16'(sel), 16'd0);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            expect_grant("rot", k % 13);
            done = 1'b1;
            tick();
            expect_idle("rot_gap");
            done = 1'b0;
        end

        // wrap-around 11 -> 12 -> 0
        req = 13'h0800;
        tick();
        expect_grant("wrap11", 11);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 13'h1001;
        tick();
        expect_grant("wrap12", 12);
        done = 1'b1;
        tick();
        expect_idle("wrap12_rel");
        done = 1'b0;
        tick();
        expect_grant("wrap0", 0);
        done = 1'b1;
        tick();
        done = 1'b0;

        // hold limit of 4 cycles, then re-grant
        req = 13'h0008;
        for (int c = 1; c <= 4; c++) begin
            tick();
            expect_grant("hold", 3);
        end
        tick();
        expect_idle("hold_expire");
        tick();
        expect_grant("hold_regrant", 3);
        tick();
        tick();
        tick();
        expect_grant("hold_c4", 3);
        done = 1'b1;
        tick();
        expect_idle("hold_double_rel");
        done = 1'b0;
        req  = 13'h1FFF;
        tick();
        expect_grant("ptr_after_double", 4);
        done = 1'b1;
        tick();
        done = 1'b0;

        // reset in the middle of a grant
        req = 13'h0200;
        tick();
        expect_grant("mid", 9);
        req = 13'h0201;
        rst = 1'b1;
        tick();
        expect_idle("mid_rst");
        chk("mid_rst_sel", 16'(sel), 16'd0);
        rst = 1'b0;
        tick();
        expect_grant("mid_after", 0);

        inv_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_13_arbiter.md
# mux_13_arbiter

Round-robin arbiter that shares one 13:1 single-bit multiplexer (4-bit select, inputs d0..d12) among 13 requesters. Each requester drives its own data line into the mux. The arbiter grants the mux to one requester at a time and drives the mux select. Grants last until the owner signals completion, drops its request, or hits a hold-time limit.

## Interface
- MAX_HOLD, 16, maximum cycles one grant may last; 0 disables the limit
- HOLD_W, 8, width of the hold counter; MAX_HOLD < 2**HOLD_W
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  13  request vector; req[i] requests mux input di
- done  input  1  current owner releases the mux; ignored when valid=0
- gnt  output  13  one-hot grant, registered; all-zero when idle
- sel  output  4  mux select, registered; always in range 0..12
- valid  output  1  high while a grant is active (gnt != 0)

## Operation
- States: IDLE, GRANT. Reset puts the block in IDLE with gnt=0, sel=0, valid=0, pointer=0, and hold counter=0.
- Pointer (4 bits, 0..12) names the highest-priority requester.
- IDLE, any req bit set: pick the first set index k, searching pointer, pointer+1, …, 12, 0, …, pointer-1 (mod 13).
  - On that edge: gnt=1<<k, sel=k, valid=1, hold counter=1, state→GRANT.
- IDLE, req=0: stay in IDLE. gnt=0 and valid=0. sel keeps its last value.
- GRANT, release condition: any of
  - done=1
  - req[sel]=0
  - MAX_HOLD≠0 and hold counter==MAX_HOLD
- On a release edge: gnt=0, valid=0, pointer=(sel==12)?0:sel+1, hold counter=0, state→IDLE. sel keeps its value.
- GRANT, no release: hold counter increments and saturates at 2**HOLD_W-1. gnt, sel and valid are unchanged.
- Several release conditions in the same cycle produce one release, and the pointer advances once.
- Req bits other than the owner's have no effect during GRANT. Requests are not latched; a requester must hold req until granted.
- sel never takes values 13..15, because the mux output is undefined there. Bench assertion: sel ≤ 12 in every cycle.
- gnt is always zero or one-hot, and gnt[sel]==valid.
- Reset mid-grant: on the next edge, all outputs and internal state return to reset values. The pointer returns to 0.

## Timing
- Grant latency: req sampled in IDLE at edge N → gnt, sel, valid updated after edge N. There is no combinational path from req to outputs.
- Release latency: release condition sampled at edge M → gnt=0 and valid=0 after edge M.
- Every grant is followed by at least one IDLE cycle with valid=0. Back-to-back owners are therefore separated by exactly 1 idle cycle when requests are pending.
- Maximum grant duration with MAX_HOLD=H≠0: valid is high for exactly H cycles.
- Throughput, all requesters busy, done asserted on the first grant cycle: one grant per 2 cycles. Full rotation over 13 requesters takes 26 cycles.
- The mux data path is combinational from sel. Owner data is valid at the mux output in the same cycles valid=1.

## Test plan
- Reset: assert rst for 2 cycles with req=13'h1FFF → gnt=0, sel=0, valid=0 throughout. After rst drops, the first grant goes to index 0 (gnt=13'h0001).
- Single request: req=13'h0020 from IDLE → the next cycle gives gnt=13'h0020, sel=5, valid=1. Pulse done → the next cycle gives valid=0. With all requests then pending, the next grant goes to index 6.
- Full rotation: req=13'h1FFF held, done pulsed on each grant's first cycle → sel sequence 0,1,…,12,0. Each grant is separated by one valid=0 cycle, and sel stays ≤12.
- Wrap-around: grant to 11, release, then req={12,0} set → grant to 12, release, then grant to 0.
- Hold limit (MAX_HOLD=4): req=13'h0008 held, done=0 → valid high exactly 4 cycles, then 1 idle cycle, then 3 is re-granted. Also drive done=1 on the 4th grant cycle → a single release, and the pointer ends at 4.
- Reset mid-grant: rst during GRANT with sel=9 → after the edge, valid=0, gnt=0, sel=0. With req=13'h0201 pending, the next grant goes to index 0.
